// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - per-channel FIFOs feeding round-robin integer/float register-file write ports.
// Optional feature macro: WB_BYPASS_EN (an empty FIFO offers its live input to arbitration).
module wb_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*REG_ADDR_W-1:0] in_dest,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  input  logic [NUM_CH-1:0]            in_is_freg,
  output logic                         reg_w_enable,
  output logic [REG_ADDR_W-1:0]        reg_w_dest,
  output logic [DATA_W-1:0]            reg_w_data,
  output logic                         freg_w_enable,
  output logic [REG_ADDR_W-1:0]        freg_w_dest,
  output logic [DATA_W-1:0]            freg_w_data,
  output logic [NUM_CH-1:0]            retire,
  output logic                         idle
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0]     mem_data [NUM_CH][FIFO_DEPTH];
  logic [REG_ADDR_W-1:0] mem_dest [NUM_CH][FIFO_DEPTH];
  logic                  mem_freg [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr   [NUM_CH];
  logic [PTR_W-1:0]      wr_ptr   [NUM_CH];
  logic [CNT_W-1:0]      count    [NUM_CH];
  logic [CH_W-1:0]       ptr_int, ptr_flt;

  logic [NUM_CH-1:0]     cand_valid, cand_freg, from_fifo, grant, pop, push;
  logic [REG_ADDR_W-1:0] cand_dest [NUM_CH];
  logic [DATA_W-1:0]     cand_data [NUM_CH];
  logic                  int_found, flt_found, any_busy;
  logic [CH_W-1:0]       int_win, flt_win, idx_i, idx_f;

  // Candidate per channel: the FIFO head, or the live input when bypass is built in and the FIFO is empty.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c]   = count[c] < CNT_W'(FIFO_DEPTH);
      from_fifo[c]  = count[c] != '0;
      cand_valid[c] = from_fifo[c];
      cand_freg[c]  = mem_freg[c][rd_ptr[c]];
      cand_dest[c]  = mem_dest[c][rd_ptr[c]];
      cand_data[c]  = mem_data[c][rd_ptr[c]];
`ifdef WB_BYPASS_EN
      if (!from_fifo[c]) begin
        cand_valid[c] = in_valid[c];
        cand_freg[c]  = in_is_freg[c];
        cand_dest[c]  = in_dest[c*REG_ADDR_W +: REG_ADDR_W];
        cand_data[c]  = in_data[c*DATA_W +: DATA_W];
      end
`endif
    end
  end

  always_comb begin
    int_found = 1'b0;
    flt_found = 1'b0;
    int_win   = '0;
    flt_win   = '0;
    idx_i     = '0;
    idx_f     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx_i = CH_W'((int'(ptr_int) + k) % NUM_CH);
      idx_f = CH_W'((int'(ptr_flt) + k) % NUM_CH);
      if (!int_found && cand_valid[idx_i] && !cand_freg[idx_i]) begin
        int_found = 1'b1;
        int_win   = idx_i;
      end
      if (!flt_found && cand_valid[idx_f] && cand_freg[idx_f]) begin
        flt_found = 1'b1;
        flt_win   = idx_f;
      end
    end
    grant = '0;
    if (int_found) grant[int_win] = 1'b1;
    if (flt_found) grant[flt_win] = 1'b1;
  end

  // A granted bypass entry never enters the FIFO.
  always_comb begin
    pop  = grant & from_fifo;
    push = in_valid & in_ready & ~(grant & ~from_fifo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count[c]  <= '0;
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) begin
          mem_data[c][wr_ptr[c]] <= in_data[c*DATA_W +: DATA_W];
          mem_dest[c][wr_ptr[c]] <= in_dest[c*REG_ADDR_W +: REG_ADDR_W];
          mem_freg[c][wr_ptr[c]] <= in_is_freg[c];
          wr_ptr[c]              <= wr_ptr[c] + PTR_W'(1);
        end
        if (pop[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        count[c] <= count[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
      end
    end
  end

  // Writes to integer register 0 are retired but never strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_w_enable  <= 1'b0;
      reg_w_dest    <= '0;
      reg_w_data    <= '0;
      freg_w_enable <= 1'b0;
      freg_w_dest   <= '0;
      freg_w_data   <= '0;
      retire        <= '0;
      ptr_int       <= CH_W'(NUM_CH - 1);
      ptr_flt       <= CH_W'(NUM_CH - 1);
    end else begin
      reg_w_enable  <= int_found && (cand_dest[int_win] != '0);
      freg_w_enable <= flt_found;
      retire        <= grant;
      if (int_found && (cand_dest[int_win] != '0)) begin
        reg_w_dest <= cand_dest[int_win];
        reg_w_data <= cand_data[int_win];
      end
      if (flt_found) begin
        freg_w_dest <= cand_dest[flt_win];
        freg_w_data <= cand_data[flt_win];
      end
      if (int_found) ptr_int <= int_win;
      if (flt_found) ptr_flt <= flt_win;
    end
  end

  always_comb begin
    any_busy = reg_w_enable || freg_w_enable || (retire != '0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (count[c] != '0) any_busy = 1'b1;
    end
  end

  assign idle = !any_busy;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int VW    = 2 * (1 + AW + DW) + 2 * N + 1;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid, in_ready, in_is_freg, retire;
  logic [N*AW-1:0] in_dest;
  logic [N*DW-1:0] in_data;
  logic            reg_w_enable, freg_w_enable, idle;
  logic [AW-1:0]   reg_w_dest, freg_w_dest;
  logic [DW-1:0]   reg_w_data, freg_w_data;

  wb_arbiter #(.NUM_CH(N), .DATA_W(DW), .REG_ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
    .in_data(in_data), .in_is_freg(in_is_freg), .reg_w_enable(reg_w_enable),
    .reg_w_dest(reg_w_dest), .reg_w_data(reg_w_data), .freg_w_enable(freg_w_enable),
    .freg_w_dest(freg_w_dest), .freg_w_data(freg_w_data), .retire(retire), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          freg;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q [N][$];
  int            ptr_i, ptr_f;
  logic          e_wen, e_fen;
  logic [AW-1:0] e_wdest, e_fdest;
  logic [DW-1:0] e_wdata, e_fdata;
  logic [N-1:0]  e_ret;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            int_log[$];

  // Model: advance one clock edge using the inputs currently on the pins.
  task automatic model_step();
    ent_t live [N];
    ent_t cand [N];
    bit   has [N];
    bit   fromq [N];
    bit   acc [N];
    int   wi, wf;
    if (rst) begin
      for (int c = 0; c < N; c++) q[c].delete();
      ptr_i = N - 1; ptr_f = N - 1;
      e_wen = 0; e_fen = 0; e_ret = '0;
      e_wdest = '0; e_wdata = '0; e_fdest = '0; e_fdata = '0;
      return;
    end
    for (int c = 0; c < N; c++) begin
      live[c]  = {in_is_freg[c], in_dest[c*AW +: AW], in_data[c*DW +: DW]};
      acc[c]   = in_valid[c] && (q[c].size() < DEPTH);
      cand[c]  = live[c];
      has[c]   = 0;
      fromq[c] = 0;
      if (q[c].size() > 0) begin
        has[c] = 1; fromq[c] = 1; cand[c] = q[c][0];
      end
`ifdef WB_BYPASS_EN
      else if (acc[c]) has[c] = 1;
`endif
    end
    wi = -1; wf = -1;
    for (int k = 1; k <= N; k++) begin
      int i, j;
      i = (ptr_i + k) % N;
      j = (ptr_f + k) % N;
      if (wi < 0 && has[i] && !cand[i].freg) wi = i;
      if (wf < 0 && has[j] && cand[j].freg) wf = j;
    end
    e_wen = 0; e_fen = 0; e_ret = '0;
    if (wi >= 0) begin
      e_ret[wi] = 1'b1; ptr_i = wi;
      if (cand[wi].dest != 0) begin
        e_wen = 1; e_wdest = cand[wi].dest; e_wdata = cand[wi].data;
      end
    end
    if (wf >= 0) begin
      e_ret[wf] = 1'b1; ptr_f = wf;
      e_fen = 1; e_fdest = cand[wf].dest; e_fdata = cand[wf].data;
    end
    for (int c = 0; c < N; c++) begin
      if ((c == wi || c == wf) && fromq[c]) void'(q[c].pop_front());
      if (acc[c] && !((c == wi || c == wf) && !fromq[c])) q[c].push_back(live[c]);
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] rdy;
    logic         empty;
    empty = 1'b1;
    for (int c = 0; c < N; c++) begin
      rdy[c] = q[c].size() < DEPTH;
      if (q[c].size() != 0) empty = 1'b0;
    end
    return {e_wen, e_wdest, e_wdata, e_fen, e_fdest, e_fdata, e_ret,
            empty && !e_wen && !e_fen && (e_ret == '0), rdy};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {reg_w_enable, reg_w_dest, reg_w_data, freg_w_enable, freg_w_dest, freg_w_data,
            retire, idle, in_ready};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (reg_w_enable) int_log.push_back(int'(reg_w_dest));
  endtask

  task automatic clear_in();
    in_valid = '0; in_is_freg = '0; in_dest = '0; in_data = '0;
  endtask

  task automatic drive(input int c, input bit v, input bit f, input logic [AW-1:0] d, input logic [DW-1:0] x);
    in_valid[c] = v; in_is_freg[c] = f; in_dest[c*AW +: AW] = d; in_data[c*DW +: DW] = x;
  endtask

  task automatic do_reset();
    rst = 1'b1; clear_in(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_in(); tick(); rst = 1'b0;
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
    end
    n_tests++;
    if ({idle, in_ready, retire, reg_w_enable, freg_w_enable} !== {1'b1, {N{1'b1}}, {N{1'b0}}, 2'b00}) begin
      n_fail++; $display("FAIL reset_state: idle=%b ready=%b retire=%b wen=%b fen=%b", idle, in_ready, retire, reg_w_enable, freg_w_enable);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 1, 0, AW'(5), 32'hDEADBEEF);
    for (int t = 1; t <= 4; t++) begin
      tick(); clear_in();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single_vec t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
      if (t == LAT) begin
        n_tests++;
        if ({reg_w_enable, reg_w_dest, reg_w_data, retire} !== {1'b1, 5'd5, 32'hDEADBEEF, 3'b001}) begin
          n_fail++; $display("FAIL single_write: got en=%b dest=%0d data=%h ret=%b want 1 5 deadbeef 001", reg_w_enable, reg_w_dest, reg_w_data, retire);
        end
      end
    end
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_rr_burst();
    logic [31:0] got;
    do_reset();
    int_log.delete();
    repeat (2) begin
      for (int c = 0; c < N; c++) drive(c, 1, 0, AW'(c + 1), $urandom);
      repeat (5) begin
        tick(); clear_in();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL burst_vec: got %h want %h", obs_vec(), exp_vec());
        end
      end
    end
    got = '0;
    foreach (int_log[i]) got = (got << 4) | 32'(int_log[i]);
    n_tests++;
    if (got !== 32'h0012_3123 || int_log.size() != 6) begin
      n_fail++; $display("FAIL burst_order: got %h (%0d writes) want 123123", got, int_log.size());
    end
  endtask

  task automatic test_dual();
    do_reset();
    drive(0, 1, 0, AW'(7), $urandom);
    drive(2, 1, 1, AW'(9), $urandom);
    for (int t = 1; t <= 3; t++) begin
      tick(); clear_in();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL dual_vec t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
      if (t == LAT) begin
        n_tests++;
        if ({reg_w_enable, freg_w_enable, retire, reg_w_dest, freg_w_dest} !== {2'b11, 3'b101, 5'd7, 5'd9}) begin
          n_fail++; $display("FAIL dual_write: got en=%b fen=%b ret=%b d=%0d fd=%0d want 1 1 101 7 9", reg_w_enable, freg_w_enable, retire, reg_w_dest, freg_w_dest);
        end
      end
    end
  endtask

  task automatic test_x0();
    bit saw_ret, saw_wen;
    saw_ret = 0; saw_wen = 0;
    do_reset();
    drive(1, 1, 0, AW'(0), 32'h0000_1234);
    repeat (4) begin
      tick(); clear_in();
      saw_ret |= retire[1];
      saw_wen |= reg_w_enable;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL x0_vec: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({saw_ret, saw_wen} !== 2'b10) begin
      n_fail++; $display("FAIL x0_rule: got retire=%b wen=%b want 1 0", saw_ret, saw_wen);
    end
  endtask

  task automatic test_backpressure();
    int acc1, first_low, since, served, next_out;
    acc1 = 0; first_low = -1; since = 0; served = 0; next_out = 0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      drive(0, 1, 0, AW'($urandom_range(1, 31)), $urandom);
      drive(2, 1, 0, AW'($urandom_range(1, 31)), $urandom);
      drive(1, 1, 0, AW'(11), 32'(acc1));
      if (!in_ready[1] && first_low < 0) first_low = acc1;
      if (in_ready[1]) acc1++;
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bp_vec t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
      if (retire != '0) since++;
      if (retire[1]) begin
        n_tests++;
        if (since > N || reg_w_data !== 32'(next_out)) begin
          n_fail++; $display("FAIL bp_fair: got gap=%0d data=%0d want gap<=%0d data=%0d", since, reg_w_data, N, next_out);
        end
        since = 0; served++; next_out++;
      end
    end
    clear_in();
    repeat (8) tick();
    n_tests++;
    if (served < 10) begin
      n_fail++; $display("FAIL bp_served: got %0d want >=10", served);
    end
`ifndef WB_BYPASS_EN
    n_tests++;
    if (first_low != 2) begin
      n_fail++; $display("FAIL bp_ready_drop: got %0d accepted want 2", first_low);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) begin
      for (int c = 0; c < N; c++) drive(c, 1, 1'($urandom), AW'($urandom_range(1, 31)), $urandom);
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mid_fill_vec: got %h want %h", obs_vec(), exp_vec());
      end
    end
    rst = 1'b1; tick(); rst = 1'b0; clear_in();
    n_tests++;
    if ({reg_w_enable, freg_w_enable, retire, in_ready, idle} !== {2'b00, {N{1'b0}}, {N{1'b1}}, 1'b1}) begin
      n_fail++; $display("FAIL mid_reset: got wen=%b fen=%b ret=%b rdy=%b idle=%b", reg_w_enable, freg_w_enable, retire, in_ready, idle);
    end
    repeat (3) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec() || reg_w_enable || freg_w_enable) begin
        n_fail++; $display("FAIL mid_quiet: got %h want %h", obs_vec(), exp_vec());
      end
    end
    drive(2, 1, 0, AW'(13), $urandom);
    for (int t = 1; t <= LAT + 1; t++) begin
      tick(); clear_in();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mid_post_vec: got %h want %h", obs_vec(), exp_vec());
      end
      if (t == LAT) begin
        n_tests++;
        if ({reg_w_enable, reg_w_dest, retire} !== {1'b1, 5'd13, 3'b100}) begin
          n_fail++; $display("FAIL mid_post_write: got en=%b dest=%0d ret=%b want 1 13 100", reg_w_enable, reg_w_dest, retire);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < N; c++)
        drive(c, $urandom_range(0, 9) < 6, 1'($urandom), AW'($urandom_range(0, 31)), $urandom);
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_vec t=%0d: got %h want %h", t, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; clear_in();
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_single();
    test_rr_burst();
    test_dual();
    test_x0();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
